// File: rtl/dual_port_bram_byte_en.sv
// True dual-port synchronous block RAM with per-byte write enables.
// Registered reads, write-first on the same port; the other port sees the
// pre-edge contents. When both ports write the same byte of the same word
// in one cycle, port 2 wins. Includes a cycle counter and a
// simulation-only scan printer.
module dual_port_bram_byte_en #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 8,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000,
  parameter int NUM_BYTES       = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  readEnable_1,
  input  logic                  writeEnable_1,
  input  logic [NUM_BYTES-1:0]  writeByteEnable_1,
  input  logic [ADDR_WIDTH-1:0] address_1,
  input  logic [DATA_WIDTH-1:0] writeData_1,
  output logic [DATA_WIDTH-1:0] readData_1,
  input  logic                  readEnable_2,
  input  logic                  writeEnable_2,
  input  logic [NUM_BYTES-1:0]  writeByteEnable_2,
  input  logic [ADDR_WIDTH-1:0] address_2,
  input  logic [DATA_WIDTH-1:0] writeData_2,
  output logic [DATA_WIDTH-1:0] readData_2,
  input  logic                  scan
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // NOTE: the storage array has no reset. Clearing a RAM on reset would
  // turn it into flops. It is zeroed once at time 0 and then keeps its
  // contents across resets.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] r_rd_1;
  logic [DATA_WIDTH-1:0] r_rd_2;
  logic [31:0]           r_cycle;
  logic [DATA_WIDTH-1:0] w_merged_1;
  logic [DATA_WIDTH-1:0] w_merged_2;

  // Form the write-first read word for each port: its own enabled write
  // bytes overlay the pre-edge memory word.
  // NOTE: always_comb uses blocking assignments, and each output gets its
  // default first. The default is what prevents a latch.
  always_comb begin
    w_merged_1 = r_mem[address_1];
    w_merged_2 = r_mem[address_2];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (writeEnable_1 && writeByteEnable_1[i]) begin
        w_merged_1[8*i +: 8] = writeData_1[8*i +: 8];
      end
      if (writeEnable_2 && writeByteEnable_2[i]) begin
        w_merged_2[8*i +: 8] = writeData_2[8*i +: 8];
      end
    end
  end

  // Byte-lane writes from both ports. Writes are blocked while reset is
  // low. Port 2 is assigned last, so it wins a same-byte collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (writeEnable_1 && writeByteEnable_1[i]) begin
          r_mem[address_1][8*i +: 8] <= writeData_1[8*i +: 8];
        end
      end
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (writeEnable_2 && writeByteEnable_2[i]) begin
          r_mem[address_2][8*i +: 8] <= writeData_2[8*i +: 8];
        end
      end
    end
  end

  // Port 1 read register: loads on readEnable, otherwise holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_1 <= '0;
    end else if (readEnable_1) begin
      r_rd_1 <= w_merged_1;
    end
  end

  // Port 2 read register: loads on readEnable, otherwise holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_2 <= '0;
    end else if (readEnable_2) begin
      r_rd_2 <= w_merged_2;
    end
  end

  // Free-running cycle counter used to window the scan output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  assign readData_1 = r_rd_1;
  assign readData_2 = r_rd_2;

`ifndef SYNTHESIS
  // Debug trace of both ports, once per cycle, inside the cycle window.
  always_ff @(posedge clock) begin
    if (scan && (r_cycle >= 32'(SCAN_CYCLES_MIN)) && (r_cycle <= 32'(SCAN_CYCLES_MAX))) begin
      $display("[bram core %0d cycle %0d] p1 re=%b we=%b be=%b a=%h wd=%h rd=%h | p2 re=%b we=%b be=%b a=%h wd=%h rd=%h",
               CORE, r_cycle,
               readEnable_1, writeEnable_1, writeByteEnable_1, address_1, writeData_1, r_rd_1,
               readEnable_2, writeEnable_2, writeByteEnable_2, address_2, writeData_2, r_rd_2);
    end
  end
`endif

endmodule

// File: tb/tb_dual_port_bram_byte_en.sv
// Self-checking bench for dual_port_bram_byte_en. A directed vector table
// is followed by a hand-written reset sequence and randomized traffic that
// is checked against a behavioural model. Expected read data goes into a
// scoreboard queue when the stimulus is driven and is compared after the
// clock edge.
module tb_dual_port_bram_byte_en;

  logic        clock = 1'b0;
  logic        reset;
  logic        re1, we1, re2, we2, scan;
  logic [3:0]  be1, be2;
  logic [7:0]  a1, a2;
  logic [31:0] wd1, wd2;
  logic [31:0] rd1, rd2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic re1; logic we1; logic [3:0] be1; logic [7:0] a1; logic [31:0] wd1;
    logic re2; logic we2; logic [3:0] be2; logic [7:0] a2; logic [31:0] wd2;
    logic [31:0] exp1; logic [31:0] exp2;
  } vec_t;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[13];
  logic [31:0] m_mem [256];
  logic [31:0] m_rd1, m_rd2;

  dual_port_bram_byte_en dut (
    .clock(clock), .reset(reset),
    .readEnable_1(re1), .writeEnable_1(we1), .writeByteEnable_1(be1),
    .address_1(a1), .writeData_1(wd1), .readData_1(rd1),
    .readEnable_2(re2), .writeEnable_2(we2), .writeByteEnable_2(be2),
    .address_2(a2), .writeData_2(wd2), .readData_2(rd2),
    .scan(scan)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic re1_i, input logic we1_i, input logic [3:0] be1_i, input logic [7:0] a1_i, input logic [31:0] wd1_i,
    input logic re2_i, input logic we2_i, input logic [3:0] be2_i, input logic [7:0] a2_i, input logic [31:0] wd2_i,
    input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.re1 = re1_i; v.we1 = we1_i; v.be1 = be1_i; v.a1 = a1_i; v.wd1 = wd1_i;
    v.re2 = re2_i; v.we2 = we2_i; v.be2 = be2_i; v.a2 = a2_i; v.wd2 = wd2_i;
    v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  task automatic drive_idle();
    re1 = 0; we1 = 0; be1 = '0; a1 = '0; wd1 = '0;
    re2 = 0; we2 = 0; be2 = '0; a2 = '0; wd2 = '0;
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clock);
    re1 = v.re1; we1 = v.we1; be1 = v.be1; a1 = v.a1; wd1 = v.wd1;
    re2 = v.re2; we2 = v.we2; be2 = v.be2; a2 = v.a2; wd2 = v.wd2;
    sb.push_back('{v.exp1, v.exp2, tag});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.tag, "_rd1"}, rd1, e.rd1);
    check({e.tag, "_rd2"}, rd2, e.rd2);
  endtask

  initial begin
    vec_t r;
    logic [31:0] e1, e2;

    vecs[0]  = mk(0,1,4'hF,8'd0,32'd10,        0,1,4'hF,8'd1,32'd11,        32'h0,        32'h0);
    vecs[1]  = mk(1,0,4'h0,8'd0,32'h0,         1,0,4'h0,8'd1,32'h0,         32'd10,       32'd11);
    vecs[2]  = mk(1,1,4'hF,8'd0,32'h0,         1,1,4'hF,8'd1,32'h0,         32'h0,        32'h0);
    vecs[3]  = mk(1,1,4'hC,8'd0,32'hCCCCBBBB,  1,1,4'h3,8'd1,32'hDDDDEEEE,  32'hCCCC0000, 32'h0000EEEE);
    vecs[4]  = mk(1,1,4'h3,8'd0,32'hBBBBCCCC,  1,1,4'hC,8'd1,32'hEEEEDDDD,  32'hCCCCCCCC, 32'hEEEEEEEE);
    vecs[5]  = mk(0,1,4'hF,8'd5,32'h11111111,  0,1,4'h3,8'd5,32'h22222222,  32'hCCCCCCCC, 32'hEEEEEEEE);
    vecs[6]  = mk(1,0,4'h0,8'd5,32'h0,         1,0,4'h0,8'd5,32'h0,         32'h11112222, 32'h11112222);
    vecs[7]  = mk(0,1,4'h1,8'd5,32'hAAAAAAAA,  1,0,4'h0,8'd5,32'h0,         32'h11112222, 32'h11112222);
    vecs[8]  = mk(1,0,4'h0,8'd5,32'h0,         1,0,4'h0,8'd5,32'h0,         32'h111122AA, 32'h111122AA);
    vecs[9]  = mk(0,0,4'h0,8'd0,32'h0,         1,0,4'h0,8'd200,32'h0,       32'h111122AA, 32'h0);
    vecs[10] = mk(1,1,4'hC,8'd7,32'h33333333,  1,1,4'h6,8'd7,32'h44444444,  32'h33330000, 32'h00444400);
    vecs[11] = mk(1,0,4'h0,8'd7,32'h0,         1,0,4'h0,8'd7,32'h0,         32'h33444400, 32'h33444400);
    vecs[12] = mk(1,0,4'h0,8'd0,32'h0,         1,0,4'h0,8'd1,32'h0,         32'hCCCCCCCC, 32'hEEEEEEEE);

    scan = 0;
    drive_idle();
    reset = 0;
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1;

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in mid-cycle: outputs clear with no clock edge.
    #2;
    reset = 0;
    #1;
    check("async_reset_rd1", rd1, 32'h0);
    check("async_reset_rd2", rd2, 32'h0);
    // A write attempted while reset is low must be dropped.
    apply(mk(1,1,4'hF,8'd0,32'h12345678, 1,1,4'hF,8'd1,32'h87654321, 32'h0, 32'h0), "write_in_reset");
    @(negedge clock);
    drive_idle();
    reset = 1;
    apply(mk(1,0,4'h0,8'd0,32'h0, 1,0,4'h0,8'd1,32'h0, 32'hCCCCCCCC, 32'hEEEEEEEE), "after_reset");

    // Random traffic on a small address window so the ports collide often.
    for (int k = 0; k < 256; k++) m_mem[k] = '0;
    m_rd1 = 32'hCCCCCCCC;
    m_rd2 = 32'hEEEEEEEE;
    for (int n = 0; n < 200; n++) begin
      scan = (n >= 10 && n < 13);
      r.re1 = 1'($urandom_range(0, 1)); r.we1 = 1'($urandom_range(0, 1));
      r.be1 = 4'($urandom); r.a1 = 8'(16 + $urandom_range(0, 3)); r.wd1 = $urandom;
      r.re2 = 1'($urandom_range(0, 1)); r.we2 = 1'($urandom_range(0, 1));
      r.be2 = 4'($urandom); r.a2 = 8'(16 + $urandom_range(0, 3)); r.wd2 = $urandom;
      e1 = m_rd1;
      e2 = m_rd2;
      if (r.re1) begin
        e1 = m_mem[r.a1];
        for (int b = 0; b < 4; b++) if (r.we1 && r.be1[b]) e1[8*b +: 8] = r.wd1[8*b +: 8];
      end
      if (r.re2) begin
        e2 = m_mem[r.a2];
        for (int b = 0; b < 4; b++) if (r.we2 && r.be2[b]) e2[8*b +: 8] = r.wd2[8*b +: 8];
      end
      for (int b = 0; b < 4; b++) if (r.we1 && r.be1[b]) m_mem[r.a1][8*b +: 8] = r.wd1[8*b +: 8];
      for (int b = 0; b < 4; b++) if (r.we2 && r.be2[b]) m_mem[r.a2][8*b +: 8] = r.wd2[8*b +: 8];
      m_rd1 = e1;
      m_rd2 = e2;
      r.exp1 = e1;
      r.exp2 = e2;
      apply(r, $sformatf("rand%0d", n));
    end
    scan = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
